branch_history_table: RTL
=========================

// Module: branch_history_table
// PURPOSE
//  Parametrised branch direction predictor: table of ENTRIES saturating counters, CTR_W bits each.
//  Optional gshare indexing XORs the PC index with a global history register (GHR).
//  Sits beside the fetch stage: fetch queries by PC; execute resolves branches and trains the table.
//  Generalises the fixed 2-bit single-mode predictor: width, depth, history and indexing mode are parameters.
//  Adds a self-initialising table and a flush-to-reinit sequencer.
// PARAMETERS
//  PC_W     64  PC width in bits
//  ENTRIES  64  number of counters; power of two, >= 2
//  CTR_W    2   counter width in bits; legal range 2..4
//  HIST_W   6   GHR length in bits; must be <= IDX_W
//  GSHARE   1   1 = index is PC bits XOR GHR; 0 = index is PC bits only
//  IDX_W    $clog2(ENTRIES)  derived index width; not overridable
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  flush_i       in   1       reinitialise table and clear GHR
//  ready_o       out  1       1 = table initialised; queries and updates accepted
//  pred_valid_i  in   1       prediction request
//  pred_pc_i     in   PC_W    PC of the instruction being fetched
//  pred_valid_o  out  1       prediction result valid, one cycle after request
//  pred_taken_o  out  1       predicted direction (1 = taken)
//  pred_hist_o   out  HIST_W  GHR value used for this prediction; carried down the pipe
//  upd_valid_i   in   1       resolved-branch update
//  upd_pc_i      in   PC_W    PC of the resolved branch
//  upd_hist_i    in   HIST_W  pred_hist_o value captured when this branch was predicted
//  upd_taken_i   in   1       actual branch outcome
// BEHAVIOUR
//  Reset and clocking:
//  - One clock domain. rst_n is asynchronous assert, synchronous deassert by the system.
//  - Reset values: state INIT, init_idx 0, GHR 0, ready_o 0, pred_valid_o 0, pred_taken_o 0, pred_hist_o 0.
//  - The counter array is not reset directly; the INIT sequencer writes it.
//  Indexing:
//  - Index = pc[IDX_W+1:2] (4-byte instructions), XOR {0, GHR} when GSHARE = 1.
//  - Prediction uses the live GHR. Update uses upd_hist_i.
//  Counters:
//  - Unsigned, range 0..2^CTR_W-1. Taken is predicted when ctr >= 2^(CTR_W-1) (MSB set).
//  - Update: taken increments, saturating at max; not-taken decrements, saturating at 0.
//  - Init value is 2^(CTR_W-1)-1 (weakly not-taken).
//  FSM:
//  - INIT: writes the init value to entry init_idx, then increments init_idx; ready_o = 0.
//    Requests and updates are ignored: pred_valid_o stays 0, no table write, no GHR change.
//    After writing entry ENTRIES-1, moves to READY. INIT therefore lasts exactly ENTRIES cycles.
//  - READY: ready_o = 1. flush_i moves to INIT with init_idx 0 and GHR 0 on the next edge.
//  - flush_i asserted during INIT restarts the sequence at init_idx 0.
//  - flush_i has priority over a same-cycle update; that update is dropped.
//  - rst_n low at any point aborts all activity and returns every register to its reset value.
//  Prediction (READY only):
//  - Request at cycle t: pred_valid_o = 1 at t+1 with pred_taken_o and pred_hist_o registered.
//  - pred_valid_o = 0 in cycles with no accepted request. pred_taken_o and pred_hist_o hold their last values.
//  - Back-to-back requests are accepted every cycle.
//  Update (READY only):
//  - The counter write and the GHR shift occur at the edge ending cycle t.
//  - GHR becomes {GHR[HIST_W-2:0], upd_taken_i}.
//  Bypass (cycle t, request and update both valid):
//  - If the request's index equals the update's index, the prediction reflects the post-update counter.
//  - The request's index is computed with the pre-shift GHR. pred_hist_o reports that pre-shift GHR.
//  Aliasing:
//  - PCs differing only above bit IDX_W+1 share an entry; this is intended.
// TESTING
//  - Reset, defaults: release rst_n -> ready_o 0 for 64 cycles, 1 on cycle 64; first prediction of any PC = not-taken.
//  - Training, GSHARE=0, PC 0x100: two taken updates -> taken; saturation holds 3 after four more; one not-taken -> still taken (2).
//  - Bypass: PC 0x40 counter at 1; update taken and request in the same cycle -> pred_taken_o 1 on the next cycle.
//  - Gshare: GHR 6'b000001 via one taken update; PC 0x0 and PC 0x4 index entries 1 and 0 -> independent training is confirmed.
//  - Flush mid-INIT: flush_i at init cycle 30 -> ready_o rises 64 cycles after the flush, not 34.
//    Updates during INIT leave predictions unchanged.
//  - CTR_W=3, ENTRIES=16: init value 3 (not-taken); one taken update -> 4 (taken); INIT lasts 16 cycles.

Source files
------------

// File: rtl/branch_history_table.sv
// branch_history_table: saturating-counter branch predictor with optional gshare indexing and self-initialising table
// Ports: clk/rst_n (async active-low); flush_i reinitialises table and GHR; ready_o high once initialised;
// pred_valid_i/pred_pc_i query -> pred_valid_o/pred_taken_o/pred_hist_o one cycle later;
// upd_valid_i/upd_pc_i/upd_hist_i/upd_taken_i train the counter and shift the GHR.
module branch_history_table #(
    parameter int PC_W    = 64,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 6,
    parameter int GSHARE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    output logic              ready_o,
    input  logic              pred_valid_i,
    input  logic [PC_W-1:0]   pred_pc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [HIST_W-1:0] pred_hist_o,
    input  logic              upd_valid_i,
    input  logic [PC_W-1:0]   upd_pc_i,
    input  logic [HIST_W-1:0] upd_hist_i,
    input  logic              upd_taken_i
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  init_idx, init_idx_nx;
    logic [HIST_W-1:0] ghr, ghr_nx;
    logic [CTR_W-1:0]  ctr_mem [ENTRIES];
    logic [IDX_W-1:0]  pred_idx, upd_idx;
    logic [CTR_W-1:0]  upd_old, upd_new, pred_ctr;
    logic              pred_acc, upd_acc;
    logic              unused_pc_bits;

    function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hist);
        return pc[IDX_W+1:2] ^ (GSHARE != 0 ? IDX_W'(hist) : '0);
    endfunction

    assign unused_pc_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0], upd_pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0]};

    assign ready_o  = state == READY;
    assign pred_acc = ready_o && pred_valid_i;
    // flush wins over a same-cycle update, so the update is simply not accepted
    assign upd_acc  = ready_o && upd_valid_i && !flush_i;
    assign pred_idx = idx_of(pred_pc_i, ghr);
    assign upd_idx  = idx_of(upd_pc_i, upd_hist_i);
    assign upd_old  = ctr_mem[upd_idx];
    assign upd_new  = upd_taken_i ? (upd_old == CTR_MAX ? upd_old : upd_old + 1'b1)
                                  : (upd_old == '0 ? upd_old : upd_old - 1'b1);
    // same-cycle update to the requested entry is forwarded so the prediction sees the trained value
    assign pred_ctr = (upd_acc && upd_idx == pred_idx) ? upd_new : ctr_mem[pred_idx];

    always_comb begin
        state_nx    = state;
        init_idx_nx = init_idx;
        ghr_nx      = ghr;
        if (flush_i) begin
            state_nx    = INIT;
            init_idx_nx = '0;
            ghr_nx      = '0;
        end else if (state == INIT) begin
            init_idx_nx = init_idx + 1'b1;
            state_nx    = init_idx == IDX_W'(ENTRIES - 1) ? READY : INIT;
        end else if (upd_acc) begin
            ghr_nx = HIST_W'({ghr, upd_taken_i});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            init_idx     <= '0;
            ghr          <= '0;
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_hist_o  <= '0;
        end else begin
            state        <= state_nx;
            init_idx     <= init_idx_nx;
            ghr          <= ghr_nx;
            pred_valid_o <= pred_acc;
            if (pred_acc) begin
                pred_taken_o <= pred_ctr[CTR_W-1];
                pred_hist_o  <= ghr;
            end
        end
    end

    // counter array has no reset; the INIT sequencer fills it
    always_ff @(posedge clk) begin
        if (state == INIT)
            ctr_mem[init_idx] <= CTR_INIT;
        else if (upd_acc)
            ctr_mem[upd_idx] <= upd_new;
    end
endmodule
